// File: rtl/rv16_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshake, register-file write port,
// issue/scoreboard signals and, with RV16_WB_BYPASS_EN, the forwarding ports.
interface rv16_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [ADDR_W-1:0]         o_rd_addr;
  logic [DATA_W-1:0]         o_rd_data;
  logic                      o_write_enable;
  logic                      i_issue_valid;
  logic [ADDR_W-1:0]         i_issue_addr;
  logic [(1<<ADDR_W)-1:0]    o_busy;
`ifdef RV16_WB_BYPASS_EN
  logic [ADDR_W-1:0]         i_rs1_addr;
  logic [ADDR_W-1:0]         i_rs2_addr;
  logic [DATA_W-1:0]         i_rs1_rf_data;
  logic [DATA_W-1:0]         i_rs2_rf_data;
  logic [DATA_W-1:0]         o_rs1_data;
  logic [DATA_W-1:0]         o_rs2_data;

  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_issue_valid, i_issue_addr,
    output i_rs1_addr, i_rs2_addr, i_rs1_rf_data, i_rs2_rf_data,
    input  o_req_ready, o_rd_addr, o_rd_data, o_write_enable, o_busy,
    input  o_rs1_data, o_rs2_data
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data, i_issue_valid, i_issue_addr,
    input  i_rs1_addr, i_rs2_addr, i_rs1_rf_data, i_rs2_rf_data,
    output o_req_ready, o_rd_addr, o_rd_data, o_write_enable, o_busy,
    output o_rs1_data, o_rs2_data
  );
`else
  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_issue_valid, i_issue_addr,
    input  o_req_ready, o_rd_addr, o_rd_data, o_write_enable, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data, i_issue_valid, i_issue_addr,
    output o_req_ready, o_rd_addr, o_rd_data, o_write_enable, o_busy
  );
`endif
endinterface

// File: rtl/rv16_wb_arbiter.sv
// Round-robin writeback arbiter with a registered write stage and a per-register
// pending-write scoreboard. Define RV16_WB_BYPASS_EN to add write-to-read forwarding.
module rv16_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input logic              clk,
  input logic              rst_n,
  rv16_wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [PTR_W-1:0]    rr_ptr_q;
  logic                we_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_found;
  logic [PTR_W-1:0]    ptr_next;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_data;
  int unsigned         scan_idx;
  logic                xfer;

  // Scan requesters from the rr pointer, wrapping, and grant the first valid one.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    ptr_next  = rr_ptr_q;
    gnt_addr  = '0;
    gnt_data  = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_found && bus.i_req_valid[scan_idx]) begin
        gnt_found     = 1'b1;
        gnt[scan_idx] = 1'b1;
        ptr_next      = PTR_W'((scan_idx + 1) % NUM_REQ);
        gnt_addr      = bus.i_req_addr[scan_idx*ADDR_W +: ADDR_W];
        gnt_data      = bus.i_req_data[scan_idx*DATA_W +: DATA_W];
      end
    end
  end

  // The grant is the ready; a found grant is always a transfer.
  assign bus.o_req_ready = rst_n ? gnt : '0;
  assign xfer            = rst_n & gnt_found;

  // Write stage: capture the winner; x0 writes consume the slot but never write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (xfer) begin
      rr_ptr_q <= ptr_next;
      we_q     <= (gnt_addr != '0);
      if (gnt_addr != '0) begin
        rd_addr_q <= gnt_addr;
        rd_data_q <= gnt_data;
      end
    end else begin
      we_q <= 1'b0;
    end
  end

  // Scoreboard next state: clear on write, then set on issue so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (bus.i_issue_valid && (bus.i_issue_addr != '0)) begin
      busy_d[bus.i_issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.o_write_enable = we_q;
  assign bus.o_rd_addr      = rd_addr_q;
  assign bus.o_rd_data      = rd_data_q;
  assign bus.o_busy         = busy_q;

`ifdef RV16_WB_BYPASS_EN
  // Forward the in-flight write to readers of the same non-zero register.
  always_comb begin
    bus.o_rs1_data = bus.i_rs1_rf_data;
    bus.o_rs2_data = bus.i_rs2_rf_data;
    if (we_q && (rd_addr_q == bus.i_rs1_addr) && (bus.i_rs1_addr != '0)) begin
      bus.o_rs1_data = rd_data_q;
    end
    if (we_q && (rd_addr_q == bus.i_rs2_addr) && (bus.i_rs2_addr != '0)) begin
      bus.o_rs2_data = rd_data_q;
    end
  end
`endif
endmodule

// File: tb/tb_rv16_wb_arbiter.sv
// Bench for rv16_wb_arbiter: directed scenarios then randomized traffic against a
// transaction-level reference model.
module tb_rv16_wb_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rv16_wb_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  rv16_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  int          last_grant;

  function automatic int model_grant(logic [NR-1:0] v, int p);
    for (int i = 0; i < NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int k, bit v, logic [4:0] a, logic [31:0] d);
    bus.i_req_valid[k]        = v;
    bus.i_req_addr[k*AW +: AW] = a;
    bus.i_req_data[k*DW +: DW] = d;
  endtask

  // One clock: check ready, advance model, check registered outputs after the edge.
  task automatic cycle();
    int          g;
    logic [2:0]  exp_rdy;
    logic [4:0]  ga;
    bit          n_we;
    logic [31:0] n_busy;
    #1;
    g = rst_n ? model_grant(bus.i_req_valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    check("ready", {29'b0, bus.o_req_ready}, {29'b0, exp_rdy});
`ifdef RV16_WB_BYPASS_EN
    check("rs1_fwd", bus.o_rs1_data,
          (m_we && m_addr == bus.i_rs1_addr && bus.i_rs1_addr != 0) ? m_data : bus.i_rs1_rf_data);
    check("rs2_fwd", bus.o_rs2_data,
          (m_we && m_addr == bus.i_rs2_addr && bus.i_rs2_addr != 0) ? m_data : bus.i_rs2_rf_data);
`endif
    last_grant = g;
    if (!rst_n) begin
      m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;
    end else begin
      n_busy = m_busy;
      if (m_we) n_busy[m_addr] = 1'b0;
      if (bus.i_issue_valid && bus.i_issue_addr != 0) n_busy[bus.i_issue_addr] = 1'b1;
      n_we = 0;
      if (g >= 0) begin
        ga    = bus.i_req_addr[g*AW +: AW];
        m_ptr = (g + 1) % NR;
        n_we  = (ga != 0);
        if (ga != 0) begin
          m_addr = ga;
          m_data = bus.i_req_data[g*DW +: DW];
        end
      end
      m_we   = n_we;
      m_busy = n_busy;
    end
    @(posedge clk);
    #1;
    check("write_enable", {31'b0, bus.o_write_enable}, {31'b0, m_we});
    check("rd_addr", {27'b0, bus.o_rd_addr}, {27'b0, m_addr});
    check("rd_data", bus.o_rd_data, m_data);
    check("busy", bus.o_busy, m_busy);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, 5'd0, 32'd0);
    bus.i_issue_valid = 1'b0;
    bus.i_issue_addr  = 5'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;
    last_grant = -1;
    idle_inputs();
`ifdef RV16_WB_BYPASS_EN
    bus.i_rs1_addr = 0; bus.i_rs2_addr = 0;
    bus.i_rs1_rf_data = 32'h11; bus.i_rs2_rf_data = 32'h22;
`endif

    // Reset with every requester valid.
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 5'(k + 1), 32'(k));
    bus.i_issue_valid = 1'b1;
    bus.i_issue_addr  = 5'd9;
    cycle();
    cycle();
    check("reset_busy_zero", bus.o_busy, 32'd0);
    rst_n = 1'b1;
    idle_inputs();

    // Single requester.
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    idle_inputs();
    check("single_we", {31'b0, bus.o_write_enable}, 32'd1);
    check("single_data", bus.o_rd_data, 32'hDEADBEEF);
    cycle();

    // Round-robin from pointer 0: requesters keep requesting with fresh data.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 5'(10 + k), 32'h100 + 32'(k));
    for (int n = 0; n < 4; n++) begin
      cycle();
      check("rr_order", 32'(last_grant), 32'(n % NR));
      set_req(last_grant, 1'b1, 5'(20 + n), 32'h200 + 32'(n));
    end
    idle_inputs();
    cycle();

    // x0 write: accepted, no write, scoreboard untouched.
    set_req(1, 1'b1, 5'd0, 32'hCAFE);
    cycle();
    idle_inputs();
    check("x0_no_we", {31'b0, bus.o_write_enable}, 32'd0);

    // Scoreboard: set, write with same-cycle reissue, then a clearing write.
    bus.i_issue_valid = 1'b1;
    bus.i_issue_addr  = 5'd7;
    cycle();
    idle_inputs();
    check("busy7_set", {31'b0, bus.o_busy[7]}, 32'd1);
    set_req(0, 1'b1, 5'd7, 32'h77);
    cycle();
    idle_inputs();
    bus.i_issue_valid = 1'b1;
    bus.i_issue_addr  = 5'd7;
    cycle();
    idle_inputs();
    check("busy7_set_wins", {31'b0, bus.o_busy[7]}, 32'd1);
    set_req(2, 1'b1, 5'd7, 32'h78);
    cycle();
    idle_inputs();
    cycle();
    check("busy7_cleared", {31'b0, bus.o_busy[7]}, 32'd0);

`ifdef RV16_WB_BYPASS_EN
    // Forwarding: write to r3 in flight, rs1 reads r3 then r0.
    set_req(0, 1'b1, 5'd3, 32'h55);
    cycle();
    idle_inputs();
    bus.i_rs1_addr = 5'd3;
    bus.i_rs1_rf_data = 32'h11;
    #1;
    check("bypass_rs1", bus.o_rs1_data, 32'h55);
    bus.i_rs1_addr = 5'd0;
    #1;
    check("bypass_rs1_x0", bus.o_rs1_data, 32'h11);
    cycle();
`endif

    // Randomized traffic; requesters hold requests until granted.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (last_grant == k || !bus.i_req_valid[k]) begin
          if ($urandom_range(0, 2) != 0) begin
            set_req(k, 1'b1, 5'($urandom_range(0, 31)), $urandom);
          end else begin
            set_req(k, 1'b0, 5'd0, 32'd0);
          end
        end
      end
      bus.i_issue_valid = ($urandom_range(0, 9) < 3);
      bus.i_issue_addr  = 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 59) != 0);
`ifdef RV16_WB_BYPASS_EN
      bus.i_rs1_addr    = m_we && $urandom_range(0, 1) == 1 ? m_addr : 5'($urandom_range(0, 31));
      bus.i_rs2_addr    = 5'($urandom_range(0, 31));
      bus.i_rs1_rf_data = $urandom;
      bus.i_rs2_rf_data = $urandom;
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
